// File: rtl/timing_sequencer_if.sv
// timing_sequencer_if
//  Bundles the sequencer's bus and control signals.
//  slave  : the timing sequencer itself (consumes control inputs, drives T/OP state)
//  master : the environment / control decoder side (drives inputs, reads state)
//  Inputs to sequencer : rdy, dataIn, lastCycle, skip, nmiPend, irqPend, iFlag
//  Outputs of sequencer: T, OP, prevOP, activeInt, sync, nmiAck, badSeq
interface timing_sequencer_if;
  logic       rdy;
  logic [7:0] dataIn;
  logic       lastCycle;
  logic       skip;
  logic       nmiPend;
  logic       irqPend;
  logic       iFlag;
  logic [6:0] T;
  logic [7:0] OP;
  logic [7:0] prevOP;
  logic [2:0] activeInt;
  logic       sync;
  logic       nmiAck;
  logic       badSeq;

  modport slave (
    input  rdy, dataIn, lastCycle, skip, nmiPend, irqPend, iFlag,
    output T, OP, prevOP, activeInt, sync, nmiAck, badSeq
  );

  modport master (
    output rdy, dataIn, lastCycle, skip, nmiPend, irqPend, iFlag,
    input  T, OP, prevOP, activeInt, sync, nmiAck, badSeq
  );
endinterface

// File: rtl/timing_sequencer.sv
// timing_sequencer
//  Instruction timing front end for the 6502C core. Produces the one-hot T-state
//  vector, latches the opcode at fetch, keeps the previous opcode for deferred T2
//  write-back, and injects BRK for reset/NMI/IRQ entry.
//  Ports:
//   phi2 : core clock, all state changes on its rising edge
//   RES  : synchronous active-low reset
//   bus  : timing_sequencer_if.slave (rdy, dataIn, lastCycle, skip, nmiPend,
//          irqPend, iFlag in; T, OP, prevOP, activeInt, sync, nmiAck, badSeq out)
module timing_sequencer #(
  parameter logic [7:0] BRK_OP  = 8'h00,
  parameter logic [7:0] IDLE_OP = 8'hEA
) (
  input logic                 phi2,
  input logic                 RES,
  timing_sequencer_if.slave   bus
);

  localparam logic [6:0] T0 = 7'b0000001;
  localparam logic [6:0] T1 = 7'b0000010;
  localparam logic [6:0] T2 = 7'b0000100;

  localparam logic [2:0] INT_NONE = 3'b000;
  localparam logic [2:0] INT_IRQ  = 3'b001;
  localparam logic [2:0] INT_NMI  = 3'b010;
  localparam logic [2:0] INT_RST  = 3'b100;

  // Opcode fetch is the only cycle with sync high; decoded straight from T.
  assign bus.sync = bus.T[1];

  // Sequencing register. Priority inside an enabled edge: leaving T0/T1 always goes
  // to T2 (lastCycle/skip ignored there), then lastCycle, then skip (only from T2..T4),
  // then T6 overrun recovery, then plain advance. The pulse outputs default low each
  // edge so they last exactly one cycle and stay low while frozen by rdy.
  always_ff @(posedge phi2) begin
    if (!RES) begin
      bus.T         <= T0;
      bus.OP        <= BRK_OP;
      bus.prevOP    <= IDLE_OP;
      bus.activeInt <= INT_RST;
      bus.nmiAck    <= 1'b0;
      bus.badSeq    <= 1'b0;
    end else begin
      bus.nmiAck <= 1'b0;
      bus.badSeq <= 1'b0;
      if (bus.rdy) begin
        if (bus.T[0]) begin
          // Reset vector sequence runs as a BRK; OP and activeInt already set.
          bus.T <= T2;
        end else if (bus.T[1]) begin
          bus.T      <= T2;
          bus.prevOP <= bus.OP;
          if (bus.nmiPend) begin
            bus.OP        <= BRK_OP;
            bus.activeInt <= INT_NMI;
            bus.nmiAck    <= 1'b1;
          end else if (bus.irqPend && !bus.iFlag) begin
            bus.OP        <= BRK_OP;
            bus.activeInt <= INT_IRQ;
          end else begin
            bus.OP        <= bus.dataIn;
            bus.activeInt <= INT_NONE;
          end
        end else if (bus.lastCycle) begin
          bus.T         <= T1;
          bus.activeInt <= INT_NONE;
        end else if (bus.skip && (bus.T[6:5] == 2'b00)) begin
          bus.T <= bus.T << 2;
        end else if (bus.T[6]) begin
          // Ran past T6 without the decoder ending the instruction: recover to fetch.
          bus.T      <= T1;
          bus.badSeq <= 1'b1;
        end else begin
          bus.T <= bus.T << 1;
        end
      end
    end
  end

endmodule

// File: tb/tb_timing_sequencer.sv
// tb_timing_sequencer
//  Directed self-checking bench for timing_sequencer. Inputs change 1 time unit after
//  each rising edge and outputs are sampled at the same point.
module tb_timing_sequencer;

  logic phi2;
  logic RES;
  int   assertionCount;
  int   failCount;

  timing_sequencer_if bus();

  timing_sequencer dut (
    .phi2 (phi2),
    .RES  (RES),
    .bus  (bus.slave)
  );

  initial phi2 = 1'b0;
  always #5 phi2 = ~phi2;

  localparam logic [6:0] S0 = 7'b0000001;
  localparam logic [6:0] S1 = 7'b0000010;
  localparam logic [6:0] S2 = 7'b0000100;
  localparam logic [6:0] S3 = 7'b0001000;
  localparam logic [6:0] S4 = 7'b0010000;
  localparam logic [6:0] S5 = 7'b0100000;
  localparam logic [6:0] S6 = 7'b1000000;

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertionCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Advance one clock and land 1 unit past the rising edge.
  task automatic applyStimulus(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge phi2);
      #1;
    end
  endtask

  initial begin
    assertionCount = 0;
    failCount      = 0;
    RES           = 1'b0;
    bus.rdy       = 1'b1;
    bus.dataIn    = 8'h00;
    bus.lastCycle = 1'b0;
    bus.skip      = 1'b0;
    bus.nmiPend   = 1'b0;
    bus.irqPend   = 1'b0;
    bus.iFlag     = 1'b0;

    // Reset state
    applyStimulus(2);
    checkOutput("rst_T", bus.T, S0);
    checkOutput("rst_OP", bus.OP, 8'h00);
    checkOutput("rst_prevOP", bus.prevOP, 8'hEA);
    checkOutput("rst_activeInt", bus.activeInt, 3'b100);
    checkOutput("rst_sync", bus.sync, 1'b0);
    checkOutput("rst_nmiAck", bus.nmiAck, 1'b0);
    checkOutput("rst_badSeq", bus.badSeq, 1'b0);

    // Release: T0 -> T2 -> T3 ... as a BRK
    RES = 1'b1;
    applyStimulus(1);
    checkOutput("rel_T2", bus.T, S2);
    checkOutput("rel_OP", bus.OP, 8'h00);
    checkOutput("rel_activeInt", bus.activeInt, 3'b100);
    applyStimulus(1);
    checkOutput("rel_T3", bus.T, S3);
    applyStimulus(3);
    checkOutput("rel_T6", bus.T, S6);
    bus.lastCycle = 1'b1;
    applyStimulus(1);
    checkOutput("brk_end_T1", bus.T, S1);
    checkOutput("brk_end_activeInt", bus.activeInt, 3'b000);
    checkOutput("brk_end_sync", bus.sync, 1'b1);

    // Normal fetch: 69 then E8
    bus.lastCycle = 1'b0;
    bus.dataIn    = 8'h69;
    applyStimulus(1);
    checkOutput("adc_T2", bus.T, S2);
    checkOutput("adc_OP", bus.OP, 8'h69);
    checkOutput("adc_prevOP", bus.prevOP, 8'h00);
    checkOutput("adc_sync", bus.sync, 1'b0);
    bus.lastCycle = 1'b1;
    applyStimulus(1);
    checkOutput("adc_end_T1", bus.T, S1);
    bus.lastCycle = 1'b0;
    bus.dataIn    = 8'hE8;
    applyStimulus(1);
    checkOutput("inx_T2", bus.T, S2);
    checkOutput("inx_OP", bus.OP, 8'hE8);
    checkOutput("inx_prevOP", bus.prevOP, 8'h69);

    // lastCycle during T1 is ignored
    bus.lastCycle = 1'b1;
    applyStimulus(1);
    checkOutput("lc_T1", bus.T, S1);
    applyStimulus(1);
    checkOutput("lc_at_T1_ignored", bus.T, S2);
    applyStimulus(1);
    checkOutput("lc_back_T1", bus.T, S1);
    bus.lastCycle = 1'b0;

    // IRQ taken with I=0
    bus.irqPend = 1'b1;
    bus.iFlag   = 1'b0;
    bus.dataIn  = 8'hA9;
    applyStimulus(1);
    checkOutput("irq_OP", bus.OP, 8'h00);
    checkOutput("irq_activeInt", bus.activeInt, 3'b001);
    checkOutput("irq_prevOP", bus.prevOP, 8'hE8);
    checkOutput("irq_nmiAck", bus.nmiAck, 1'b0);
    bus.irqPend   = 1'b0;
    bus.lastCycle = 1'b1;
    applyStimulus(1);
    checkOutput("irq_end_activeInt", bus.activeInt, 3'b000);
    checkOutput("irq_end_T1", bus.T, S1);

    // IRQ masked with I=1
    bus.lastCycle = 1'b0;
    bus.irqPend   = 1'b1;
    bus.iFlag     = 1'b1;
    applyStimulus(1);
    checkOutput("irqm_OP", bus.OP, 8'hA9);
    checkOutput("irqm_activeInt", bus.activeInt, 3'b000);
    bus.lastCycle = 1'b1;
    applyStimulus(1);
    checkOutput("irqm_end_T1", bus.T, S1);
    bus.lastCycle = 1'b0;

    // NMI beats IRQ; nmiAck is a single pulse
    bus.nmiPend = 1'b1;
    bus.irqPend = 1'b1;
    bus.iFlag   = 1'b0;
    applyStimulus(1);
    checkOutput("nmi_activeInt", bus.activeInt, 3'b010);
    checkOutput("nmi_OP", bus.OP, 8'h00);
    checkOutput("nmi_ack_pulse", bus.nmiAck, 1'b1);
    bus.nmiPend = 1'b0;
    bus.irqPend = 1'b0;
    applyStimulus(1);
    checkOutput("nmi_ack_drop", bus.nmiAck, 1'b0);
    checkOutput("nmi_T3", bus.T, S3);
    checkOutput("nmi_hold_activeInt", bus.activeInt, 3'b010);
    bus.lastCycle = 1'b1;
    applyStimulus(1);
    checkOutput("nmi_end_T1", bus.T, S1);
    bus.lastCycle = 1'b0;

    // Skip handling and T6 overrun
    bus.dataIn = 8'hAD;
    applyStimulus(2);
    checkOutput("skp_T3", bus.T, S3);
    bus.skip = 1'b1;
    applyStimulus(1);
    checkOutput("skip_T3_to_T5", bus.T, S5);
    applyStimulus(1);
    checkOutput("skip_T5_ignored", bus.T, S6);
    bus.skip = 1'b0;
    applyStimulus(1);
    checkOutput("ovr_T1", bus.T, S1);
    checkOutput("ovr_badSeq", bus.badSeq, 1'b1);
    bus.dataIn = 8'h4C;
    applyStimulus(1);
    checkOutput("ovr_badSeq_drop", bus.badSeq, 1'b0);
    checkOutput("ovr_OP", bus.OP, 8'h4C);
    checkOutput("ovr_prevOP", bus.prevOP, 8'hAD);

    // rdy=0 freezes mid-T4
    applyStimulus(2);
    checkOutput("frz_T4", bus.T, S4);
    bus.rdy       = 1'b0;
    bus.lastCycle = 1'b1;
    bus.nmiPend   = 1'b1;
    applyStimulus(3);
    checkOutput("frz_T", bus.T, S4);
    checkOutput("frz_OP", bus.OP, 8'h4C);
    checkOutput("frz_prevOP", bus.prevOP, 8'hAD);
    checkOutput("frz_activeInt", bus.activeInt, 3'b000);
    checkOutput("frz_nmiAck", bus.nmiAck, 1'b0);

    // Reset overrides rdy=0
    RES = 1'b0;
    applyStimulus(1);
    checkOutput("rst2_T", bus.T, S0);
    checkOutput("rst2_OP", bus.OP, 8'h00);
    checkOutput("rst2_prevOP", bus.prevOP, 8'hEA);
    checkOutput("rst2_activeInt", bus.activeInt, 3'b100);

    RES           = 1'b1;
    bus.rdy       = 1'b1;
    bus.lastCycle = 1'b0;
    bus.nmiPend   = 1'b0;
    applyStimulus(1);
    checkOutput("rel2_T2", bus.T, S2);

    $display("End of test - %0d assertions evaluated, %0d failures", assertionCount, failCount);
    $finish;
  end

endmodule
